bus_arbiter_rr16: RTL and testbench
===================================

# bus_arbiter_rr16

Round-robin arbiter and sequencer that shares one 8-bit, 16-source datapath between 16 requesters. It drives the 4-bit select of the 16:1 8-bit bus multiplexer and a valid/ready handshake toward the single consumer. Each granted requester may transfer a burst of up to MAX_BURST beats before control rotates. It sits between the requesting units (register/IO sources) and the shared bus sink.

## Interface
- MAX_BURST, 4: maximum beats per grant; legal range 1..15.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  16  per-requester request; bit i held high while requester i has data on mux input i.
- out_ready  in  1  consumer accepts a beat this cycle.
- sel  out  4  select to the 16:1 bus mux; registered.
- grant  out  16  one-hot current owner, all-zero when idle; registered.
- out_valid  out  1  beat valid toward consumer.
- ack  out  16  one-hot pulse; bit i high in the cycle a beat from requester i is accepted.
- busy  out  1  high in GRANT state.

## Operation
- States: IDLE, GRANT. The transfer beat is defined as beat = out_valid & out_ready.
- IDLE: if req != 0, the block picks the first set bit scanning ptr, ptr+1, … mod 16.
  - On the next edge: grant <= onehot(winner), sel <= winner, beat_cnt <= 0, state <= GRANT.
  - If req == 0, the block stays in IDLE.
- GRANT:
  - out_valid = req[sel] (combinational); ack = grant & {16{beat}}.
  - On each beat, beat_cnt increments.
  - Release condition: (beat & beat_cnt == MAX_BURST-1) or (!req[sel]).
  - On release: state <= IDLE, grant <= 0, ptr <= sel+1 mod 16 (15 wraps to 0). sel holds its last value.
- In IDLE: out_valid = 0 and ack = 0.
- Requester rules:
  - Keep mux input data stable while req is high.
  - Deassert req in the cycle after the ack of the last wanted beat.
  - A req drop with no beat is legal and releases the grant.
- out_ready low stalls indefinitely. There is no timeout, and the grant and beat_cnt hold.
- beat_cnt width is 4 bits. It never exceeds MAX_BURST-1.

## Timing
- Reset values: sel=0, grant=0, out_valid=0, ack=0, busy=0; internal ptr=0, beat_cnt=0, state=IDLE.
- Latency: req seen in IDLE at edge N gives grant/sel/busy valid after edge N+1. out_valid may be high in that same cycle.
- Throughput: one beat per cycle within a burst. There is exactly one IDLE bubble cycle between grants, including when the same requester is re-granted.
- Simultaneous requests: resolved strictly by rotating priority from ptr. Requests arriving during GRANT wait for the next IDLE.
- Burst cap: the capped requester with req still high is re-granted only after all other pending requesters in rotation order.
- Reset mid-burst: all state clears immediately (asynchronous). The partial burst is abandoned and no ack is issued.
- Reset deassertion: synchronised externally. The block acts on the first edge after rst_n rises.

## Structure
- Shared header scpu_defs.vh holds:
  - localparam ARB_IDLE=1'b0, ARB_GRANT=1'b1
  - NUM_SRC=16, SEL_W=4, DATA_W=8
- Sub-module rr_pick16 is purely combinational.
  - Inputs: req[15:0], ptr[3:0]. Outputs: any, idx[3:0].
  - Implemented by rotating req by ptr, applying a priority encoder, then adding ptr mod 16.
- Top level holds the FSM, beat counter, ptr register and output registers. sel connects directly to the bus mux sel.

## Test plan
- Reset then single requester: req=16'h0010 held, out_ready=1, MAX_BURST=4.
  - Required: sel=4 one cycle after req; 4 ack pulses on bit 4 in consecutive cycles; 1 IDLE bubble; then re-grant to 4.
- All requesters: req=16'hFFFF held, MAX_BURST=1.
  - Required: grant order 0,1,2,…,15,0; sel wraps 15→0; ack every other cycle.
- Stall: granted requester 7, out_ready=0 for 5 cycles, then 1.
  - Required: grant/sel=7 held, no ack during stall, beat_cnt unchanged; beats resume on ready.
- Early drop: requester 2 drops req after 2 acks (MAX_BURST=4), requester 9 pending.
  - Required: release to IDLE; next grant is 9; ptr is 3 before the pick.
- Reset mid-burst: rst_n low during a beat of requester 5.
  - Required: outputs immediately sel=0, grant=0, out_valid=0; after release with req=16'h0021, first grant goes to 0.

Source files
------------

// File: rtl/bus_arbiter_rr16_pkg.sv
// rtl/bus_arbiter_rr16_pkg.sv - shared types and sizes for the 16-source round-robin arbiter
package bus_arbiter_rr16_pkg;

    localparam int NUM_SRC = 16;
    localparam int SEL_W   = 4;
    localparam int BEAT_W  = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_SRC-1:0] onehot16(input logic [SEL_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr16_if.sv
// rtl/bus_arbiter_rr16_if.sv - requester/consumer handshake bundle of the arbiter
interface bus_arbiter_rr16_if;
    import bus_arbiter_rr16_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic               out_ready;
    logic [SEL_W-1:0]   sel;
    logic [NUM_SRC-1:0] grant;
    logic               out_valid;
    logic [NUM_SRC-1:0] ack;
    logic               busy;

    // Arbiter side: owns select, grant and the handshake toward the consumer.
    modport master (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output out_valid,
        output ack,
        output busy
    );

    // Environment side: requesters and the consumer.
    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid,
        input  ack,
        input  busy
    );

endinterface

// File: rtl/bus_arbiter_rr16_rr_pick16.sv
// rtl/bus_arbiter_rr16_rr_pick16.sv - combinational rotating-priority pick of the next owner
module rr_pick16
    import bus_arbiter_rr16_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [SEL_W-1:0]   o_idx
);

    logic [NUM_SRC-1:0] w_rot;
    logic [SEL_W-1:0]   w_off;

    // Rotate requests so that bit 0 is the requester at ptr; the 4-bit index sum wraps mod 16.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_rot[k] = i_req[SEL_W'(k) + i_ptr];
        end
    end

    // Priority encoder: lowest set bit of the rotated vector is the closest requester after ptr.
    always_comb begin
        w_off = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = w_off + i_ptr;

endmodule

// File: rtl/bus_arbiter_rr16.sv
// rtl/bus_arbiter_rr16.sv - round-robin 16-source bus arbiter with per-grant burst cap
module bus_arbiter_rr16
    import bus_arbiter_rr16_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_arbiter_rr16_if.master bus
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [NUM_SRC-1:0] r_grant;
    logic [NUM_SRC-1:0] w_grant_nxt;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [BEAT_W-1:0]  w_beat_cnt_nxt;

    logic               w_any;
    logic [SEL_W-1:0]   w_idx;
    logic               w_in_grant;
    logic               w_valid;
    logic               w_beat;
    logic               w_release;

    rr_pick16 u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    // The owner's own request is the valid; dropping it ends the grant even without a beat.
    assign w_in_grant = (r_state == ARB_GRANT);
    assign w_valid    = w_in_grant & bus.req[r_sel];
    assign w_beat     = w_valid & bus.out_ready;
    assign w_release  = w_in_grant &
                        ((w_beat & (r_beat_cnt == LAST_BEAT)) | ~bus.req[r_sel]);

    assign bus.sel       = r_sel;
    assign bus.grant     = r_grant;
    assign bus.out_valid = w_valid;
    assign bus.ack       = r_grant & {NUM_SRC{w_beat}};
    assign bus.busy      = w_in_grant;

    // Next state: pick a winner from IDLE, count beats and release from GRANT.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt    = ARB_GRANT;
                    w_sel_nxt      = w_idx;
                    w_grant_nxt    = onehot16(w_idx);
                    w_beat_cnt_nxt = '0;
                end
            end
            ARB_GRANT: begin
                if (w_release) begin
                    // sel is left on the last owner; only ptr moves past it.
                    w_state_nxt    = ARB_IDLE;
                    w_grant_nxt    = '0;
                    w_ptr_nxt      = r_sel + SEL_W'(1);
                    w_beat_cnt_nxt = '0;
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State register; reset abandons any partial burst at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Select, grant, rotation pointer and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= '0;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr16.sv
// tb/tb_bus_arbiter_rr16.sv - self-checking bench for bus_arbiter_rr16
module tb_bus_arbiter_rr16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    int exp4[$];
    int exp1[$];
    int e4;
    int e1;

    bus_arbiter_rr16_if b4();
    bus_arbiter_rr16_if b1();

    bus_arbiter_rr16 #(.MAX_BURST(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.master)
    );

    bus_arbiter_rr16 #(.MAX_BURST(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    always #5 clk = ~clk;

    // Scoreboard for the burst-4 instance: every ack pops the expected owner.
    always @(negedge clk) begin
        if (rst_n && b4.ack !== 16'h0) begin
            checks++;
            if (exp4.size() == 0) begin
                errors++;
                $display("FAIL ack4_unexpected got=%h expected none", b4.ack);
            end else begin
                e4 = exp4.pop_front();
                if (b4.ack !== (16'h1 << e4)) begin
                    errors++;
                    $display("FAIL ack4_owner got=%h expected=%h", b4.ack, 16'h1 << e4);
                end
            end
        end
    end

    // Scoreboard for the burst-1 instance.
    always @(negedge clk) begin
        if (rst_n && b1.ack !== 16'h0) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL ack1_unexpected got=%h expected none", b1.ack);
            end else begin
                e1 = exp1.pop_front();
                if (b1.ack !== (16'h1 << e1)) begin
                    errors++;
                    $display("FAIL ack1_owner got=%h expected=%h", b1.ack, 16'h1 << e1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        b4.req = '0; b4.out_ready = 1'b0;
        b1.req = '0; b1.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (b4.sel !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0d expected=0", b4.sel); end
        checks++; if (b4.grant !== 16'h0) begin errors++; $display("FAIL reset_grant got=%h expected=0000", b4.grant); end
        checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b expected=0", b4.out_valid); end
        checks++; if (b4.ack !== 16'h0) begin errors++; $display("FAIL reset_ack got=%h expected=0000", b4.ack); end
        checks++; if (b4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", b4.busy); end
        checks++; if (b1.grant !== 16'h0 || b1.busy !== 1'b0) begin errors++; $display("FAIL reset_dut1 grant=%h busy=%b expected 0000/0", b1.grant, b1.busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        b4.req = 16'h0010; b4.out_ready = 1'b1;
        repeat (8) exp4.push_back(4);
        @(negedge clk);
        checks++; if (b4.busy !== 1'b0 || b4.out_valid !== 1'b0) begin errors++; $display("FAIL single_pre_grant busy=%b out_valid=%b expected 0/0", b4.busy, b4.out_valid); end
        @(negedge clk);
        checks++; if (b4.sel !== 4'd4) begin errors++; $display("FAIL single_sel got=%0d expected=4", b4.sel); end
        checks++; if (b4.grant !== 16'h0010 || b4.busy !== 1'b1) begin errors++; $display("FAIL single_grant got=%h busy=%b expected=0010/1", b4.grant, b4.busy); end
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            checks++; if (b4.ack !== 16'h0010) begin errors++; $display("FAIL single_ack%0d got=%h expected=0010", i, b4.ack); end
        end
        @(negedge clk);
        checks++; if (b4.busy !== 1'b0 || b4.grant !== 16'h0 || b4.ack !== 16'h0) begin errors++; $display("FAIL single_bubble busy=%b grant=%h ack=%h expected 0/0000/0000", b4.busy, b4.grant, b4.ack); end
        checks++; if (b4.sel !== 4'd4) begin errors++; $display("FAIL single_sel_hold got=%0d expected=4", b4.sel); end
        @(negedge clk);
        checks++; if (b4.grant !== 16'h0010 || b4.sel !== 4'd4) begin errors++; $display("FAIL single_regrant grant=%h sel=%0d expected=0010/4", b4.grant, b4.sel); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        b4.req = '0;
        repeat (3) @(negedge clk);
        checks++; if (exp4.size() != 0 || b4.busy !== 1'b0) begin errors++; $display("FAIL single_drain left=%0d busy=%b expected 0/0", exp4.size(), b4.busy); end
    endtask

    task automatic test_all_rr();
        @(posedge clk); #1;
        b1.req = 16'hFFFF; b1.out_ready = 1'b1;
        for (int k = 0; k < 17; k++) exp1.push_back(k % 16);
        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            checks++; if (b1.sel !== 4'(k % 16) || b1.grant !== (16'h1 << (k % 16))) begin errors++; $display("FAIL all_grant%0d sel=%0d grant=%h expected sel=%0d", k, b1.sel, b1.grant, k % 16); end
            @(negedge clk);
            checks++; if (b1.busy !== 1'b0 || b1.ack !== 16'h0) begin errors++; $display("FAIL all_bubble%0d busy=%b ack=%h expected 0/0000", k, b1.busy, b1.ack); end
        end
        @(posedge clk); #1;
        b1.req = '0;
        repeat (3) @(negedge clk);
        checks++; if (exp1.size() != 0) begin errors++; $display("FAIL all_drain left=%0d expected=0", exp1.size()); end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        b4.req = 16'h0080; b4.out_ready = 1'b0;
        repeat (4) exp4.push_back(7);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (b4.grant !== 16'h0080 || b4.sel !== 4'd7 || b4.out_valid !== 1'b1 || b4.ack !== 16'h0) begin
                errors++; $display("FAIL stall%0d grant=%h sel=%0d out_valid=%b ack=%h expected 0080/7/1/0000", i, b4.grant, b4.sel, b4.out_valid, b4.ack);
            end
        end
        @(posedge clk); #1;
        b4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (b4.ack !== 16'h0080) begin errors++; $display("FAIL stall_resume%0d got=%h expected=0080", i, b4.ack); end
        end
        @(posedge clk); #1;
        b4.req = '0;
        @(negedge clk);
        checks++; if (b4.busy !== 1'b0 || exp4.size() != 0) begin errors++; $display("FAIL stall_capped busy=%b left=%0d expected 0/0", b4.busy, exp4.size()); end
    endtask

    task automatic test_early_drop();
        @(posedge clk); #1;
        b4.req = 16'h0004; b4.out_ready = 1'b1;
        exp4.push_back(2); exp4.push_back(2);
        repeat (4) exp4.push_back(9);
        repeat (4) exp4.push_back(1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (b4.sel !== 4'd2 || b4.ack !== 16'h0004) begin errors++; $display("FAIL drop_first sel=%0d ack=%h expected 2/0004", b4.sel, b4.ack); end
        @(posedge clk); #1;
        b4.req = 16'h0206;
        @(negedge clk);
        @(posedge clk); #1;
        b4.req = 16'h0202;
        @(negedge clk);
        checks++; if (b4.busy !== 1'b1 || b4.out_valid !== 1'b0 || b4.ack !== 16'h0) begin errors++; $display("FAIL drop_noack busy=%b out_valid=%b ack=%h expected 1/0/0000", b4.busy, b4.out_valid, b4.ack); end
        @(negedge clk);
        checks++; if (b4.busy !== 1'b0 || b4.grant !== 16'h0) begin errors++; $display("FAIL drop_release busy=%b grant=%h expected 0/0000", b4.busy, b4.grant); end
        @(negedge clk);
        checks++; if (b4.sel !== 4'd9 || b4.grant !== 16'h0200) begin errors++; $display("FAIL drop_next sel=%0d grant=%h expected 9/0200", b4.sel, b4.grant); end
        repeat (4) @(negedge clk);
        @(negedge clk);
        checks++; if (b4.sel !== 4'd1 || b4.grant !== 16'h0002) begin errors++; $display("FAIL cap_rotation sel=%0d grant=%h expected 1/0002", b4.sel, b4.grant); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        b4.req = '0;
        repeat (2) @(negedge clk);
        checks++; if (exp4.size() != 0 || b4.busy !== 1'b0) begin errors++; $display("FAIL drop_drain left=%0d busy=%b expected 0/0", exp4.size(), b4.busy); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        b4.req = 16'h0020; b4.out_ready = 1'b1;
        exp4.push_back(5);
        @(negedge clk);
        @(negedge clk);
        checks++; if (b4.sel !== 4'd5 || b4.ack !== 16'h0020) begin errors++; $display("FAIL rstmid_beat sel=%0d ack=%h expected 5/0020", b4.sel, b4.ack); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (b4.sel !== 4'd0 || b4.grant !== 16'h0 || b4.out_valid !== 1'b0 || b4.ack !== 16'h0 || b4.busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear sel=%0d grant=%h out_valid=%b ack=%h busy=%b expected all zero", b4.sel, b4.grant, b4.out_valid, b4.ack, b4.busy);
        end
        b4.req = 16'h0021;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) exp4.push_back(0);
        repeat (4) exp4.push_back(5);
        @(negedge clk);
        @(negedge clk);
        checks++; if (b4.sel !== 4'd0 || b4.grant !== 16'h0001) begin errors++; $display("FAIL rstmid_first sel=%0d grant=%h expected 0/0001", b4.sel, b4.grant); end
        repeat (3) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (b4.sel !== 4'd5 || b4.grant !== 16'h0020) begin errors++; $display("FAIL rstmid_second sel=%0d grant=%h expected 5/0020", b4.sel, b4.grant); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        b4.req = '0;
        repeat (2) @(negedge clk);
        checks++; if (exp4.size() != 0) begin errors++; $display("FAIL rstmid_drain left=%0d expected=0", exp4.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rr();
        test_stall();
        test_early_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
